interpreter_byte_streamer: RTL

// - Downstream of data memory; feeds the external interpreter link.
// - Captures the selected byte of each memory read word issued while the CPU is in

---
 rtl/interpreter_byte_streamer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/interpreter_byte_streamer.sv
// -----------------------------------------------------------------------------
// interpreter_byte_streamer
//
// Purpose:
//   Sits downstream of data memory. One byte lane of every memory read word
//   that the CPU loads while in communication mode (MemtoReg & COMFlag) is
//   queued in a FIFO. Queued bytes are replayed to an external host over an
//   8-bit bus using a 4-phase strobe/acknowledge handshake, so CPU loads never
//   stall on host speed.
//
// Parameters:
//   DEPTH         FIFO entries (power of 2, >= 2)
//   SETUP_CYCLES  cycles ReadDataOut is stable before clk_out rises (>= 1)
//   BYTE_SEL      byte lane of ReadData captured (0 = [7:0] .. 3 = [31:24])
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   MemtoReg     in   memory-to-register load in the M stage
//   COMFlag      in   CPU communication mode
//   ReadData     in   32-bit data memory read word
//   host_ack     in   host acknowledge, asynchronous to clk
//   clk_out      out  data strobe to host
//   ReadDataOut  out  byte presented to host
//   fifo_full    out  FIFO holds DEPTH entries
//   fifo_empty   out  FIFO holds 0 entries
//   overflow     out  sticky: a capture was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module interpreter_byte_streamer #(
    parameter int DEPTH        = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int BYTE_SEL     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoReg,
    input  logic        COMFlag,
    input  logic [31:0] ReadData,
    input  logic        host_ack,
    output logic        clk_out,
    output logic [7:0]  ReadDataOut,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;

    logic          ack_meta_r;
    logic          ack_sync_r;   // synchronized host_ack; the only ack the FSM sees

    state_t        state_r;
    logic [SW-1:0] setup_cnt_r;
    logic          clk_out_r;
    logic [7:0]    rdo_r;

    logic          push_req_s;
    logic          pop_s;
    logic          push_s;
    logic [7:0]    push_byte_s;

    // Only one byte lane is captured; the rest of the word is intentionally unused.
    logic          unused_read_data_s;
    assign unused_read_data_s = ^ReadData;

    // Per-cycle push/pop decisions and next occupancy.
    always_comb begin
        push_req_s  = MemtoReg & COMFlag;
        // Pop only from IDLE and only when the registered flag says data exists,
        // so a push into an empty FIFO is popped one edge later.
        pop_s       = (state_r == ST_IDLE) && !empty_r;
        // When full, a push is accepted only if a pop frees a slot on the same edge.
        push_s      = push_req_s && (!full_r || pop_s);
        push_byte_s = ReadData[8*BYTE_SEL +: 8];
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= push_byte_s;
        end
    end

    // FIFO pointers, occupancy, registered status flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == CW'(0));
            if (push_req_s && full_r && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous host acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= host_ack;
            ack_sync_r <= ack_meta_r;
        end
    end

    // Host handshake FSM with registered strobe and data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            setup_cnt_r <= {SW{1'b0}};
            clk_out_r   <= 1'b0;
            rdo_r       <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_out_r <= 1'b0;
                    if (pop_s) begin
                        // The only point where the host data bus changes.
                        rdo_r       <= mem_r[rd_ptr_r];
                        setup_cnt_r <= {SW{1'b0}};
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_r == SW'(SETUP_CYCLES - 1)) begin
                        clk_out_r <= 1'b1;
                        state_r   <= ST_STROBE;
                    end else begin
                        setup_cnt_r <= setup_cnt_r + SW'(1);
                    end
                end
                ST_STROBE: begin
                    // An ack raised early (IDLE/SETUP) is seen here on the first cycle.
                    if (ack_sync_r) begin
                        clk_out_r <= 1'b0;
                        state_r   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_sync_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    clk_out_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign clk_out     = clk_out_r;
    assign ReadDataOut = rdo_r;
    assign fifo_full   = full_r;
    assign fifo_empty  = empty_r;
    assign overflow    = overflow_r;

endmodule
